// File: rtl/sa_accept.sv
// Metropolis acceptance unit: accept if delta <= 0, otherwise accept with probability exp(-x),
// x = float(delta) * inv_temp, via an external negexp block. Includes its float multiplier.

module floating_point_mult #(
  parameter int unsigned Latency = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);
  logic [47:0]  prod;
  logic         norm, guard, sticky, rnd_up;
  logic [22:0]  mant_raw;
  logic [23:0]  mant_r;
  logic [9:0]   esum;
  logic [31:0]  res;
  logic [Latency-1:0] valid_q;
  logic [31:0]  data_q [Latency];

  // Round-to-nearest-even; subnormals flush to zero, NaN/Inf inputs are not special-cased.
  always_comb begin
    prod = {1'b1, s_axis_a_tdata[22:0]} * {1'b1, s_axis_b_tdata[22:0]};
    norm = prod[47];
    if (norm) begin
      mant_raw = prod[46:24];
      guard    = prod[23];
      sticky   = |prod[22:0];
    end else begin
      mant_raw = prod[45:23];
      guard    = prod[22];
      sticky   = |prod[21:0];
    end
    rnd_up = guard && (sticky || mant_raw[0]);
    mant_r = {1'b0, mant_raw} + {23'b0, rnd_up};
    esum   = {2'b0, s_axis_a_tdata[30:23]} + {2'b0, s_axis_b_tdata[30:23]} + {9'b0, norm}
             + {9'b0, mant_r[23]};
    if (s_axis_a_tdata[30:23] == 8'd0 || s_axis_b_tdata[30:23] == 8'd0 || esum <= 10'd127) begin
      res = {s_axis_a_tdata[31] ^ s_axis_b_tdata[31], 31'b0};
    end else if (esum >= 10'd382) begin
      res = {s_axis_a_tdata[31] ^ s_axis_b_tdata[31], 8'hff, 23'b0};
    end else begin
      res = {s_axis_a_tdata[31] ^ s_axis_b_tdata[31], 8'(esum - 10'd127), mant_r[22:0]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= s_axis_a_tvalid && s_axis_b_tvalid;
      for (int unsigned i = 1; i < Latency; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge aclk) begin
    data_q[0] <= res;
    for (int unsigned i = 1; i < Latency; i++) data_q[i] <= data_q[i-1];
  end

  assign m_axis_result_tvalid = valid_q[Latency-1];
  assign m_axis_result_tdata  = data_q[Latency-1];
endmodule

module sa_accept #(
  parameter int unsigned MultLatency = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] delta,
  input  logic [31:0] inv_temp,
  input  logic [23:0] rand_bits,
  output logic [31:0] exp_inp,
  output logic        exp_inp_valid,
  input  logic [31:0] exp_out,
  input  logic        exp_out_valid,
  output logic        resp_valid,
  output logic        resp_accept
);
  localparam logic [31:0] Clamp = 32'h3fc0_0000;

  typedef enum logic [2:0] {StIdle, StConv, StMult, StExp, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic        mult_start_q, mult_start_d;
  logic [23:0] rand_q, rand_d;
  logic [31:0] exp_inp_q, exp_inp_d;
  logic        exp_inp_valid_q, exp_inp_valid_d;
  logic        resp_valid_q, resp_valid_d;
  logic        accept_q, accept_d;
  logic        prod_valid;
  logic [31:0] prod;
  logic [4:0]  msb;
  logic [22:0] delta_mant;
  logic [31:0] delta_f;
  logic [7:0]  shamt;
  logic [23:0] p24;
  logic        p_zero, p_sat, prob_accept;

  floating_point_mult #(
    .Latency (MultLatency)
  ) u_mult (
    .aclk                 (clk),
    .aresetn              (!rst),
    .s_axis_a_tvalid      (mult_start_q),
    .s_axis_a_tdata       (mult_a_q),
    .s_axis_b_tvalid      (mult_start_q),
    .s_axis_b_tdata       (mult_b_q),
    .m_axis_result_tvalid (prod_valid),
    .m_axis_result_tdata  (prod)
  );

  // Positive int to float, truncating the bits below the 23-bit mantissa.
  always_comb begin
    msb = '0;
    for (int i = 0; i < 31; i++) if (delta[i]) msb = 5'(i);
    if (msb <= 5'd23) delta_mant = 23'(delta[30:0] << (5'd23 - msb));
    else              delta_mant = 23'(delta[30:0] >> (msb - 5'd23));
    delta_f = {1'b0, 8'd127 + {3'b000, msb}, delta_mant};
  end

  // Probability as Q0.24; values >= 1.0 saturate to an unconditional accept.
  always_comb begin
    shamt  = 8'd126 - exp_out[30:23];
    p_zero = exp_out[31] || (exp_out == 32'd0);
    p_sat  = !exp_out[31] && (exp_out[30:23] >= 8'd127);
    p24    = '0;
    if (!p_zero && !p_sat && shamt <= 8'd23) p24 = {1'b1, exp_out[22:0]} >> shamt;
    prob_accept = p_sat || (rand_q < p24);
  end

  always_comb begin
    state_d         = state_q;
    mult_a_d        = mult_a_q;
    mult_b_d        = mult_b_q;
    rand_d          = rand_q;
    exp_inp_d       = exp_inp_q;
    exp_inp_valid_d = 1'b0;
    accept_d        = accept_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rand_d = rand_bits;
          if ($signed(delta) <= 32'sd0) begin
            accept_d = 1'b1;
            state_d  = StResp;
          end else begin
            // Operands are converted and registered on the transfer edge so CONV carries start.
            mult_a_d = delta_f;
            mult_b_d = inv_temp;
            accept_d = 1'b0;
            state_d  = StConv;
          end
        end
      end
      StConv: state_d = StMult;
      StMult: begin
        if (prod_valid) begin
          if ((prod & 32'h7fff_ffff) >= Clamp) begin
            accept_d = 1'b0;
            state_d  = StResp;
          end else begin
            exp_inp_d       = prod | 32'h8000_0000;
            exp_inp_valid_d = 1'b1;
            state_d         = StExp;
          end
        end
      end
      StExp: begin
        if (exp_out_valid) begin
          accept_d = prob_accept;
          state_d  = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    mult_start_d = (state_d == StConv);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      mult_a_q        <= '0;
      mult_b_q        <= '0;
      mult_start_q    <= 1'b0;
      rand_q          <= '0;
      exp_inp_q       <= '0;
      exp_inp_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      accept_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      mult_a_q        <= mult_a_d;
      mult_b_q        <= mult_b_d;
      mult_start_q    <= mult_start_d;
      rand_q          <= rand_d;
      exp_inp_q       <= exp_inp_d;
      exp_inp_valid_q <= exp_inp_valid_d;
      resp_valid_q    <= resp_valid_d;
      accept_q        <= accept_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign exp_inp       = exp_inp_q;
  assign exp_inp_valid = exp_inp_valid_q;
  assign resp_valid    = resp_valid_q;
  assign resp_accept   = accept_q;
endmodule

// File: doc/sa_accept.md
# sa_accept

Metropolis acceptance unit for the simulated-annealing core. It takes a candidate move's integer cost change, the current inverse temperature (float) and a 24-bit uniform random number. It forms x = float(delta) * inv_temp and drives the `negexp` block's inp/out handshake with -x. It then compares the returned probability against the random number and emits a single-cycle accept/reject verdict. This block is the initiator side of the `negexp` interface and is the only driver of its inputs.

## Interface
- CLAMP, 32'h3fc00000 (1.5f): when x >= CLAMP the move is rejected without invoking `negexp`, because the 4-term series is inaccurate beyond this point.
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- delta  in  32  signed cost change (new - old)
- inv_temp  in  32  IEEE single, positive (1/T)
- rand  in  24  uniform random bits, treated as Q0.24
- exp_inp  out  32  to `negexp` inp
- exp_inp_valid  out  1  to `negexp` inp_valid, single-cycle pulse
- exp_out  in  32  from `negexp` out
- exp_out_valid  in  1  from `negexp` out_valid
- resp_valid  out  1  single-cycle verdict strobe
- resp_accept  out  1  1 = accept move; valid only when resp_valid is high

## Operation
- Handshake: a request transfers on a clock edge where req_valid && req_ready. On transfer, delta, inv_temp and rand are latched. One request is in flight at a time.
- Multiplier: one `floating_point_mult` instance, single-cycle start pulse on both tvalids. Its latency is arbitrary, so the block waits for m_axis_result_tvalid.
- States:
  - IDLE: req_ready=1. On transfer: if delta <= 0 (signed) go to RESP with accept=1; otherwise go to CONV.
  - CONV: convert delta to float F and register multiplier operands (F, inv_temp). Pulse start. Go to MULT.
  - MULT: wait for tvalid, then let P = product.
    - If P[30:0] >= CLAMP[30:0] (unsigned compare; both values are positive): go to RESP with accept=0.
    - Otherwise register exp_inp = {1'b1, P[30:0]}, pulse exp_inp_valid, and go to EXP.
  - EXP: wait for exp_out_valid. Compute p24 from exp_out and set accept = (rand < p24), or 1 if saturated. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_accept held. Go to IDLE.
- Int-to-float conversion (delta > 0): let k = index of the most-significant 1 bit.
  - Exponent = 127 + k.
  - Mantissa = bits k-1..0 of delta, left-aligned to 23 bits, truncated toward zero (no rounding).
  - Sign = 0.
- Probability to Q0.24 conversion from exp_out (sign s, exponent e, mantissa m):
  - s=1 or exp_out==0 → p24=0, so reject.
  - e >= 127 (value ≥ 1.0) → saturate, accept=1.
  - Otherwise p24 = {1,m} >> (126-e); a shift > 23 gives 0.
- exp_out_valid outside EXP is ignored. req_valid outside IDLE is ignored.

## Timing
- Reset values (cycle of and cycle after rst):
  - Outputs: resp_valid=0, resp_accept=0, exp_inp_valid=0, exp_inp=0.
  - Internal: state=IDLE, multiplier start=0.
  - req_ready=1 on the first cycle after rst deasserts.
- Reset mid-operation: abort to IDLE. No resp_valid is produced for the aborted request. A late multiplier tvalid or exp_out_valid is ignored.
- delta <= 0: transfer at edge N; resp_valid is high during cycle N+1; req_ready is high again at N+2.
- Full path, measured from the transfer edge:
  - Multiplier start is high 1 cycle after transfer (CONV).
  - exp_inp_valid is asserted the cycle after tvalid is seen.
  - resp_valid is asserted the cycle after exp_out_valid is seen.
- Clamp path: resp_valid is asserted the cycle after tvalid.
- All outputs are registered. resp_valid and exp_inp_valid are never high for two consecutive cycles.

## Test plan
- delta=-5 (any inv_temp, rand) -> resp_valid exactly 1 cycle after transfer, resp_accept=1, exp_inp_valid never asserted. Repeat with delta=0 -> same.
- delta=10, inv_temp=0x3dcccccd (0.1) -> exp_inp=0xbf800000 with a one-cycle exp_inp_valid. The negexp model returns 0x3ec00000 (0.375, so p24=0x600000):
  - rand=0x5fffff -> resp_accept=1.
  - rand=0x600000 -> resp_accept=0.
- delta=100, inv_temp=0x3f800000 -> P=0x42c80000 >= CLAMP -> resp_accept=0, exp_inp_valid never asserted.
- delta=0x7fffffff, inv_temp=0x30000000 (2^-31) -> F=0x4effffff (truncated), exp_inp=0xbf7fffff. Model returns 0x3f800000 -> saturated, resp_accept=1 even with rand=0xffffff.
- Model returns 0xbd000000 (negative) -> resp_accept=0 with rand=0.
- Robustness:
  - Assert rst for 1 cycle while in EXP; then pulse exp_out_valid -> no resp_valid. The next request completes normally.
  - req_valid held high throughout a busy period -> exactly one request transferred per IDLE visit.
  - Multiplier model latency varied between 1 and 8 cycles -> verdicts unchanged.
